// File: rtl/mips_hilo_unit_pkg.sv
// Shared types and constants for the MIPS HI/LO multiply/divide unit.
// Select encodings match the controller's hi_select/lo_select fields.
package mips_hilo_unit_pkg;

  localparam int HI_LO_SEL_WIDTH = 2;
  localparam int MD_ITERATIONS   = 32;
  localparam int MD_CNT_W        = $clog2(MD_ITERATIONS);

  typedef enum logic [HI_LO_SEL_WIDTH-1:0] {
    HL_HOLD = 2'b00,
    HL_MOVE = 2'b01,
    HL_DIV  = 2'b10,
    HL_MULT = 2'b11
  } hilo_sel_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_FIX  = 2'b10
  } md_state_t;

endpackage

// File: rtl/mips_md_iter.sv
// Unsigned iterative datapath: shift-add multiply or restoring divide,
// one bit per step. Operands must already be magnitudes.
module mips_md_iter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      load,
  input  logic                      step,
  input  logic                      is_div,
  input  logic [DATA_WIDTH-1:0]     op_a,
  input  logic [DATA_WIDTH-1:0]     op_b,
  output logic [2*DATA_WIDTH-1:0]   acc
);

  // acc_q packs {partial, low}: product {hi,lo} for MULT, {remainder, quotient} for DIV
  logic [2*DATA_WIDTH-1:0] acc_q;
  logic [DATA_WIDTH-1:0]   m_q;
  logic                    div_q;

  logic [DATA_WIDTH-1:0]   acc_hi;
  logic [DATA_WIDTH-1:0]   acc_lo;
  logic [DATA_WIDTH:0]     add_sum;
  logic [DATA_WIDTH:0]     shifted;
  logic                    fits;
  logic [DATA_WIDTH-1:0]   rem_sub;
  logic [2*DATA_WIDTH-1:0] mul_next;
  logic [2*DATA_WIDTH-1:0] div_next;

  always_comb begin
    acc_hi   = acc_q[2*DATA_WIDTH-1:DATA_WIDTH];
    acc_lo   = acc_q[DATA_WIDTH-1:0];
    add_sum  = {1'b0, acc_hi} + {1'b0, m_q};
    mul_next = acc_lo[0] ? {add_sum, acc_lo[DATA_WIDTH-1:1]}
                         : {1'b0, acc_hi, acc_lo[DATA_WIDTH-1:1]};
    // Remainder shifts left taking the next dividend bit; subtract only if it fits
    shifted  = {acc_hi, acc_lo[DATA_WIDTH-1]};
    fits     = shifted >= {1'b0, m_q};
    rem_sub  = DATA_WIDTH'(shifted - {1'b0, m_q});
    div_next = fits ? {rem_sub, acc_lo[DATA_WIDTH-2:0], 1'b1}
                    : {shifted[DATA_WIDTH-1:0], acc_lo[DATA_WIDTH-2:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (load) begin
      div_q <= is_div;
      m_q   <= is_div ? op_b : op_a;
      acc_q <= {{DATA_WIDTH{1'b0}}, (is_div ? op_a : op_b)};
    end else if (step) begin
      acc_q <= div_q ? div_next : mul_next;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/mips_hilo_unit.sv
// HI/LO owner: decodes controller requests, sequences the iterative
// multiply/divide, applies sign fix-up and raises stall for HI/LO hazards.
module mips_hilo_unit
  import mips_hilo_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       hi_write,
  input  logic                       lo_write,
  input  logic [HI_LO_SEL_WIDTH-1:0] hi_select,
  input  logic [HI_LO_SEL_WIDTH-1:0] lo_select,
  input  logic                       hilo_read,
  input  logic [DATA_WIDTH-1:0]      rs_data,
  input  logic [DATA_WIDTH-1:0]      rt_data,
  output logic [DATA_WIDTH-1:0]      hi_q,
  output logic [DATA_WIDTH-1:0]      lo_q,
  output logic                       busy,
  output logic                       stall
);

  function automatic logic [DATA_WIDTH-1:0] magnitude(input logic signed [DATA_WIDTH-1:0] v);
    return v[DATA_WIDTH-1] ? -v : v;
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] apply_sign(input logic [DATA_WIDTH-1:0] mag,
                                                               input logic neg);
    return neg ? -mag : mag;
  endfunction

  function automatic logic signed [2*DATA_WIDTH-1:0] apply_sign_wide(input logic [2*DATA_WIDTH-1:0] mag,
                                                                     input logic neg);
    return neg ? -mag : mag;
  endfunction

  hilo_sel_t hi_sel;
  hilo_sel_t lo_sel;
  logic      start_mul;
  logic      start_div;
  logic      mov_hi;
  logic      mov_lo;
  logic      accept;

  assign hi_sel    = hilo_sel_t'(hi_select);
  assign lo_sel    = hilo_sel_t'(lo_select);
  assign start_mul = hi_write & lo_write & (hi_sel == HL_MULT) & (lo_sel == HL_MULT);
  assign start_div = hi_write & lo_write & (hi_sel == HL_DIV)  & (lo_sel == HL_DIV);
  assign mov_hi    = hi_write & (hi_sel == HL_MOVE);
  assign mov_lo    = lo_write & (lo_sel == HL_MOVE);

  md_state_t            state_q;
  md_state_t            state_d;
  logic [MD_CNT_W-1:0]  cnt_q;

  assign busy   = (state_q != MD_IDLE);
  assign stall  = busy & (hilo_read | start_mul | start_div | mov_hi | mov_lo);
  assign accept = (state_q == MD_IDLE) & (start_mul | start_div);

  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (accept) state_d = MD_RUN;
      MD_RUN:  if (cnt_q == MD_CNT_W'(MD_ITERATIONS - 1)) state_d = MD_FIX;
      MD_FIX:  state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept)
        cnt_q <= '0;
      else if (state_q == MD_RUN)
        cnt_q <= cnt_q + MD_CNT_W'(1);
    end
  end

  // ---- accept stage: capture operation attributes for the fix-up ----
  logic signed [DATA_WIDTH-1:0] rs_s;
  logic signed [DATA_WIDTH-1:0] rt_s;
  logic                         op_div_q;
  logic                         neg_q;
  logic                         rem_neg_q;
  logic                         div_zero_q;
  logic [DATA_WIDTH-1:0]        rs_save_q;

  assign rs_s = rs_data;
  assign rt_s = rt_data;

  always_ff @(posedge clk) begin
    if (accept) begin
      op_div_q   <= start_div;
      neg_q      <= rs_s[DATA_WIDTH-1] ^ rt_s[DATA_WIDTH-1];
      rem_neg_q  <= rs_s[DATA_WIDTH-1];
      div_zero_q <= (rt_data == '0);
      rs_save_q  <= rs_data;
    end
  end

  // ---- run stage: unsigned iteration on magnitudes ----
  logic [2*DATA_WIDTH-1:0] acc;

  mips_md_iter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_iter (
    .clk    (clk),
    .load   (accept),
    .step   (state_q == MD_RUN),
    .is_div (start_div),
    .op_a   (magnitude(rs_s)),
    .op_b   (magnitude(rt_s)),
    .acc    (acc)
  );

  // ---- fix stage: sign correction and HI/LO write ----
  logic [2*DATA_WIDTH-1:0] fix_result;

  always_comb begin
    fix_result = apply_sign_wide(acc, neg_q);
    if (op_div_q) begin
      if (div_zero_q)
        fix_result = {rs_save_q, {DATA_WIDTH{1'b1}}};
      else
        fix_result = {apply_sign(acc[2*DATA_WIDTH-1:DATA_WIDTH], rem_neg_q),
                      apply_sign(acc[DATA_WIDTH-1:0], neg_q)};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state_q == MD_FIX) begin
      hi_q <= fix_result[2*DATA_WIDTH-1:DATA_WIDTH];
      lo_q <= fix_result[DATA_WIDTH-1:0];
    end else if (state_q == MD_IDLE) begin
      if (mov_hi) hi_q <= rs_data;
      if (mov_lo) lo_q <= rs_data;
    end
  end

endmodule

// File: tb/tb_mips_hilo_unit.sv
// Self-checking bench for mips_hilo_unit with a 64-bit arithmetic reference model.
module tb_mips_hilo_unit;

  logic        clk;
  logic        rst_n;
  logic        hi_write;
  logic        lo_write;
  logic [1:0]  hi_select;
  logic [1:0]  lo_select;
  logic        hilo_read;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy;
  logic        stall;

  int n_cmp = 0;
  int n_err = 0;

  mips_hilo_unit #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hi_write  (hi_write),
    .lo_write  (lo_write),
    .hi_select (hi_select),
    .lo_select (lo_select),
    .hilo_read (hilo_read),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .hi_q      (hi_q),
    .lo_q      (lo_q),
    .busy      (busy),
    .stall     (stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: signed 64-bit arithmetic straight from the architectural rules
  function automatic void model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] mhi, output logic [31:0] mlo);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!is_div) begin
      p   = sa * sb;
      mhi = p[63:32];
      mlo = p[31:0];
    end else if (b == 32'h0) begin
      mhi = a;
      mlo = 32'hFFFF_FFFF;
    end else begin
      q   = sa / sb;
      r   = sa % sb;
      mhi = r[31:0];
      mlo = q[31:0];
    end
  endfunction

  task automatic clear_inputs();
    hi_write  = 1'b0;
    lo_write  = 1'b0;
    hi_select = 2'b00;
    lo_select = 2'b00;
    hilo_read = 1'b0;
    rs_data   = $urandom;
    rt_data   = $urandom;
  endtask

  task automatic set_md(input bit is_div, input logic [31:0] a, input logic [31:0] b);
    hi_write  = 1'b1;
    lo_write  = 1'b1;
    hi_select = is_div ? 2'b10 : 2'b11;
    lo_select = is_div ? 2'b10 : 2'b11;
    rs_data   = a;
    rt_data   = b;
  endtask

  // Issues one operation and returns how many sampled cycles busy stayed high
  task automatic run_md(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                        output int cycles);
    @(negedge clk);
    set_md(is_div, a, b);
    @(posedge clk);
    @(negedge clk);
    clear_inputs();
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (hi_q !== 32'h0) begin n_err++; $display("FAIL reset_hi: got %h expected %h", hi_q, 32'h0); end
    n_cmp++; if (lo_q !== 32'h0) begin n_err++; $display("FAIL reset_lo: got %h expected %h", lo_q, 32'h0); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst_n = 1'b1;
    hilo_read = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b expected 0", stall); end
    hilo_read = 1'b0;
  endtask

  task automatic test_moves();
    @(negedge clk);
    hi_write = 1'b1; hi_select = 2'b01; rs_data = 32'hA5A5_A5A5;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL mthi_stall: got %b expected 0", stall); end
    @(negedge clk);
    n_cmp++; if (hi_q !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL mthi_hi: got %h expected %h", hi_q, 32'hA5A5_A5A5); end
    n_cmp++; if (lo_q !== 32'h0) begin n_err++; $display("FAIL mthi_lo: got %h expected %h", lo_q, 32'h0); end
    hi_write = 1'b0; hi_select = 2'b00;
    lo_write = 1'b1; lo_select = 2'b01; rs_data = 32'h5A5A_5A5A;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL mtlo_stall: got %b expected 0", stall); end
    @(negedge clk);
    n_cmp++; if (lo_q !== 32'h5A5A_5A5A) begin n_err++; $display("FAIL mtlo_lo: got %h expected %h", lo_q, 32'h5A5A_5A5A); end
    n_cmp++; if (hi_q !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL mtlo_hi: got %h expected %h", hi_q, 32'hA5A5_A5A5); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    @(negedge clk);
    set_md(1'b0, 32'd123, 32'd456);
    @(posedge clk);
    @(negedge clk);
    clear_inputs();
    repeat (10) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midrun_busy: got %b expected 1", busy); end
    n_cmp++; if (hi_q !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL midrun_hi_hold: got %h expected %h", hi_q, 32'hA5A5_A5A5); end
    n_cmp++; if (lo_q !== 32'h5A5A_5A5A) begin n_err++; $display("FAIL midrun_lo_hold: got %h expected %h", lo_q, 32'h5A5A_5A5A); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++; if (hi_q !== 32'h0) begin n_err++; $display("FAIL abort_hi: got %h expected %h", hi_q, 32'h0); end
    n_cmp++; if (lo_q !== 32'h0) begin n_err++; $display("FAIL abort_lo: got %h expected %h", lo_q, 32'h0); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b expected 0", busy); end
    run_md(1'b0, 32'd5, 32'd7, cyc);
    n_cmp++; if (cyc != 33) begin n_err++; $display("FAIL after_abort_len: got %0d expected 33", cyc); end
    n_cmp++; if (lo_q !== 32'd35 || hi_q !== 32'h0) begin n_err++; $display("FAIL after_abort_result: got %h_%h expected %h_%h", hi_q, lo_q, 32'h0, 32'd35); end
  endtask

  task automatic test_mult();
    int cyc;
    run_md(1'b0, 32'hFFFF_FFFE, 32'd3, cyc);
    n_cmp++; if (cyc != 33) begin n_err++; $display("FAIL mult_busy_len: got %0d expected 33", cyc); end
    n_cmp++; if (hi_q !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi: got %h expected %h", hi_q, 32'hFFFF_FFFF); end
    n_cmp++; if (lo_q !== 32'hFFFF_FFFA) begin n_err++; $display("FAIL mult_lo: got %h expected %h", lo_q, 32'hFFFF_FFFA); end
  endtask

  task automatic test_div();
    int cyc;
    run_md(1'b1, 32'hFFFF_FFF9, 32'd2, cyc);
    n_cmp++; if (cyc != 33) begin n_err++; $display("FAIL div_busy_len: got %0d expected 33", cyc); end
    n_cmp++; if (lo_q !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_lo: got %h expected %h", lo_q, 32'hFFFF_FFFD); end
    n_cmp++; if (hi_q !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_hi: got %h expected %h", hi_q, 32'hFFFF_FFFF); end
    run_md(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    n_cmp++; if (lo_q !== 32'h8000_0000) begin n_err++; $display("FAIL div_ovf_lo: got %h expected %h", lo_q, 32'h8000_0000); end
    n_cmp++; if (hi_q !== 32'h0) begin n_err++; $display("FAIL div_ovf_hi: got %h expected %h", hi_q, 32'h0); end
  endtask

  task automatic test_div_zero();
    int cyc;
    run_md(1'b1, 32'h0000_1234, 32'h0, cyc);
    n_cmp++; if (cyc != 33) begin n_err++; $display("FAIL divz_busy_len: got %0d expected 33", cyc); end
    n_cmp++; if (hi_q !== 32'h0000_1234) begin n_err++; $display("FAIL divz_hi: got %h expected %h", hi_q, 32'h0000_1234); end
    n_cmp++; if (lo_q !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL divz_lo: got %h expected %h", lo_q, 32'hFFFF_FFFF); end
  endtask

  task automatic test_hazard();
    int waited;
    int bad;
    @(negedge clk);
    set_md(1'b0, 32'd5, 32'd6);
    @(posedge clk);
    @(negedge clk);
    clear_inputs();
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL hazard_busy: got %b expected 1", busy); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL hazard_add_stall: got %b expected 0", stall); end
    @(negedge clk);
    hilo_read = 1'b1;
    #1;
    waited = 1;
    bad = 0;
    while (busy === 1'b1 && waited < 100) begin
      if (stall !== 1'b1) bad++;
      waited++;
      @(negedge clk);
    end
    n_cmp++; if (waited != 33) begin n_err++; $display("FAIL hazard_busy_len: got %0d expected 33", waited); end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL hazard_stall_gap: got %0d unstalled cycles expected 0", bad); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL hazard_release: got %b expected 0", stall); end
    n_cmp++; if (lo_q !== 32'd30) begin n_err++; $display("FAIL hazard_mflo: got %h expected %h", lo_q, 32'd30); end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    int waited;
    int bad;
    logic [31:0] dh, dl, mh, ml;
    model(1'b1, 32'hFFFF_FF9C, 32'd7, dh, dl);
    model(1'b0, 32'h0001_2345, 32'hFFFE_0001, mh, ml);
    @(negedge clk);
    set_md(1'b1, 32'hFFFF_FF9C, 32'd7);
    @(posedge clk);
    @(negedge clk);
    set_md(1'b0, 32'h0001_2345, 32'hFFFE_0001);
    #1;
    waited = 0;
    bad = 0;
    while (busy === 1'b1 && waited < 100) begin
      if (stall !== 1'b1) bad++;
      waited++;
      @(negedge clk);
    end
    n_cmp++; if (waited != 33) begin n_err++; $display("FAIL b2b_first_len: got %0d expected 33", waited); end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL b2b_stall_gap: got %0d expected 0", bad); end
    n_cmp++; if (hi_q !== dh || lo_q !== dl) begin n_err++; $display("FAIL b2b_div_result: got %h_%h expected %h_%h", hi_q, lo_q, dh, dl); end
    @(posedge clk);
    @(negedge clk);
    clear_inputs();
    waited = 0;
    while (busy === 1'b1 && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    n_cmp++; if (waited != 33) begin n_err++; $display("FAIL b2b_second_len: got %0d expected 33", waited); end
    n_cmp++; if (hi_q !== mh || lo_q !== ml) begin n_err++; $display("FAIL b2b_mult_result: got %h_%h expected %h_%h", hi_q, lo_q, mh, ml); end
  endtask

  task automatic test_random();
    int cyc;
    bit is_div;
    logic [31:0] a, b, eh, el;
    for (int i = 0; i < 24; i++) begin
      is_div = $urandom_range(0, 1);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: a = 32'h8000_0000;
        4: b = 32'h8000_0000;
        default: ;
      endcase
      model(is_div, a, b, eh, el);
      run_md(is_div, a, b, cyc);
      n_cmp++;
      if (cyc != 33 || hi_q !== eh || lo_q !== el) begin
        n_err++;
        $display("FAIL random_%0d: op=%0d rs=%h rt=%h got %h_%h len %0d expected %h_%h len 33",
                 i, is_div, a, b, hi_q, lo_q, cyc, eh, el);
      end
    end
  endtask

  initial begin
    test_reset();
    test_moves();
    test_reset_mid_run();
    test_mult();
    test_div();
    test_div_zero();
    test_hazard();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
